// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART: FSM state encoding, parity
// mode constants, the default bit period and the parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } txState_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // 50 MHz system clock divided down to 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   // Turns the XOR of the data bits into the transmitted parity bit
   function automatic logic parityBit(input logic dataXor, input int mode);
      return (mode == PARITY_ODD) ? ~dataXor : dataXor;
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Load handshake and line outputs of the configurable UART transmitter.
// The master side offers data with i_Tx_DV, the transmitter is the slave.
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_Tx_DV;
   logic [DATA_BITS-1:0] i_Tx_Byte;
   logic                 o_Tx_Ready;
   logic                 o_Tx_Active;
   logic                 o_Tx_Serial;
   logic                 o_Tx_Done;

   modport master (
      output i_Tx_DV,
      output i_Tx_Byte,
      input  o_Tx_Ready,
      input  o_Tx_Active,
      input  o_Tx_Serial,
      input  o_Tx_Done
   );

   modport slave (
      input  i_Tx_DV,
      input  i_Tx_Byte,
      output o_Tx_Ready,
      output o_Tx_Active,
      output o_Tx_Serial,
      output o_Tx_Done
   );
endinterface

// File: rtl/uart_tx_cfg_bit_timer.sv
// Bit-period timer shared by the UART transmitter and receiver. Counts
// 0..CLKS_PER_BIT-1 while enabled and flags the terminal count with tick.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] countReg;

   // Tick is combinational so the FSM can change bit on the same edge
   // the counter wraps back to zero
   assign tick = enable && (countReg == CW'(CLKS_PER_BIT - 1));

   // Counter advances while enabled, wraps at terminal count, and is held
   // at zero by clear so every bit period starts from a known phase
   always_ff @(posedge i_Clock) begin
      if (i_Reset || clear) begin
         countReg <= '0;
      end else if (enable) begin
         if (tick) begin
            countReg <= '0;
         end else begin
            countReg <= countReg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data bits sent LSB first, optional
// odd/even parity, one or two stop bits, ready/valid load handshake. The
// serial line is registered and drives the pad directly.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PARITY_NONE,
   parameter int STOP_BITS    = 1
) (
   input logic          i_Clock,
   input logic          i_Reset,
   uart_tx_cfg_if.slave txIf
);

   if (CLKS_PER_BIT < 2) begin : g_badClks
      $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_badData
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
   end
   if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_badParity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_badStop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   txState_t             stateReg, stateNext;
   logic                 serialReg, serialNext;
   logic                 activeReg, activeNext;
   logic                 doneReg, doneNext;
   logic [3:0]           bitIdxReg, bitIdxNext;
   logic                 stopIdxReg, stopIdxNext;
   logic [DATA_BITS-1:0] dataReg, dataNext;
   logic [DATA_BITS-1:0] shiftReg, shiftNext;
   logic                 timerClear, timerEnable, bitTick;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) bitTimer (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .clear   (timerClear),
      .enable  (timerEnable),
      .tick    (bitTick)
   );

   // Ready comes straight from the state register so there is no
   // combinational path from i_Tx_DV back to the requester
   assign txIf.o_Tx_Ready  = (stateReg == S_IDLE);
   assign txIf.o_Tx_Active = activeReg;
   assign txIf.o_Tx_Serial = serialReg;
   assign txIf.o_Tx_Done   = doneReg;

   // State and registered outputs; reset abandons any frame in progress
   // without a Done pulse and wins over a simultaneous load request
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         stateReg   <= S_IDLE;
         serialReg  <= 1'b1;
         activeReg  <= 1'b0;
         doneReg    <= 1'b0;
         bitIdxReg  <= '0;
         stopIdxReg <= 1'b0;
         dataReg    <= '0;
         shiftReg   <= '0;
      end else begin
         stateReg   <= stateNext;
         serialReg  <= serialNext;
         activeReg  <= activeNext;
         doneReg    <= doneNext;
         bitIdxReg  <= bitIdxNext;
         stopIdxReg <= stopIdxNext;
         dataReg    <= dataNext;
         shiftReg   <= shiftNext;
      end
   end

   // Next-state and next-output logic. Every line change is decided one
   // cycle early so the serial output can stay registered. Parity is taken
   // from the latched copy of the data, never from the live input bus.
   always_comb begin
      stateNext   = stateReg;
      serialNext  = serialReg;
      activeNext  = activeReg;
      doneNext    = 1'b0;
      bitIdxNext  = bitIdxReg;
      stopIdxNext = stopIdxReg;
      dataNext    = dataReg;
      shiftNext   = shiftReg;
      timerClear  = 1'b0;
      timerEnable = 1'b0;

      case (stateReg)
         S_IDLE: begin
            serialNext = 1'b1;
            activeNext = 1'b0;
            timerClear = 1'b1;
            if (txIf.i_Tx_DV) begin
               dataNext    = txIf.i_Tx_Byte;
               shiftNext   = txIf.i_Tx_Byte;
               serialNext  = 1'b0;
               activeNext  = 1'b1;
               bitIdxNext  = '0;
               stopIdxNext = 1'b0;
               stateNext   = S_START;
            end
         end

         S_START: begin
            timerEnable = 1'b1;
            if (bitTick) begin
               serialNext = shiftReg[0];
               bitIdxNext = '0;
               stateNext  = S_DATA;
            end
         end

         S_DATA: begin
            timerEnable = 1'b1;
            if (bitTick) begin
               if (bitIdxReg == 4'(DATA_BITS - 1)) begin
                  stopIdxNext = 1'b0;
                  if (PARITY != PARITY_NONE) begin
                     serialNext = parityBit(^dataReg, PARITY);
                     stateNext  = S_PARITY;
                  end else begin
                     serialNext = 1'b1;
                     stateNext  = S_STOP;
                  end
               end else begin
                  shiftNext  = shiftReg >> 1;
                  serialNext = shiftReg[1];
                  bitIdxNext = bitIdxReg + 4'd1;
               end
            end
         end

         S_PARITY: begin
            timerEnable = 1'b1;
            if (bitTick) begin
               serialNext  = 1'b1;
               stopIdxNext = 1'b0;
               stateNext   = S_STOP;
            end
         end

         S_STOP: begin
            timerEnable = 1'b1;
            serialNext  = 1'b1;
            if (bitTick) begin
               if (STOP_BITS == 1 || stopIdxReg) begin
                  doneNext   = 1'b1;
                  activeNext = 1'b0;
                  stateNext  = S_IDLE;
               end else begin
                  stopIdxNext = 1'b1;
               end
            end
         end

         default: begin
            serialNext = 1'b1;
            activeNext = 1'b0;
            timerClear = 1'b1;
            stateNext  = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg. Four instances cover 8N1, 8E1, 8O1
// and 7E2 at four clocks per bit; a reference frame model fills a queue of
// expected line levels that is drained cycle by cycle against the DUT.
module tb_uart_tx_cfg;
   import uart_pkg::*;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       dv;
   logic [7:0] txByte;
   int         sel;

   int assertCount = 0;
   int failCount   = 0;
   logic expQ[$];

   int dbitsOf[4] = '{8, 8, 8, 7};
   int parOf[4]   = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_EVEN};
   int stopOf[4]  = '{1, 1, 1, 2};

   logic lineS, activeS, doneS, readyS;

   uart_tx_cfg_if #(.DATA_BITS(8)) ifA ();
   uart_tx_cfg_if #(.DATA_BITS(8)) ifB ();
   uart_tx_cfg_if #(.DATA_BITS(8)) ifC ();
   uart_tx_cfg_if #(.DATA_BITS(7)) ifD ();

   assign ifA.i_Tx_DV   = dv && (sel == 0);
   assign ifB.i_Tx_DV   = dv && (sel == 1);
   assign ifC.i_Tx_DV   = dv && (sel == 2);
   assign ifD.i_Tx_DV   = dv && (sel == 3);
   assign ifA.i_Tx_Byte = txByte;
   assign ifB.i_Tx_Byte = txByte;
   assign ifC.i_Tx_Byte = txByte;
   assign ifD.i_Tx_Byte = txByte[6:0];

   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1))
      dutA (.i_Clock(clk), .i_Reset(reset), .txIf(ifA));
   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1))
      dutB (.i_Clock(clk), .i_Reset(reset), .txIf(ifB));
   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1))
      dutC (.i_Clock(clk), .i_Reset(reset), .txIf(ifC));
   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PARITY_EVEN), .STOP_BITS(2))
      dutD (.i_Clock(clk), .i_Reset(reset), .txIf(ifD));

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Route the instance under test onto one set of observation signals
   always_comb begin
      lineS   = ifA.o_Tx_Serial;
      activeS = ifA.o_Tx_Active;
      doneS   = ifA.o_Tx_Done;
      readyS  = ifA.o_Tx_Ready;
      case (sel)
         1: begin
            lineS = ifB.o_Tx_Serial; activeS = ifB.o_Tx_Active;
            doneS = ifB.o_Tx_Done;   readyS  = ifB.o_Tx_Ready;
         end
         2: begin
            lineS = ifC.o_Tx_Serial; activeS = ifC.o_Tx_Active;
            doneS = ifC.o_Tx_Done;   readyS  = ifC.o_Tx_Ready;
         end
         3: begin
            lineS = ifD.o_Tx_Serial; activeS = ifD.o_Tx_Active;
            doneS = ifD.o_Tx_Done;   readyS  = ifD.o_Tx_Ready;
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic observed, input logic expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b (sel %0d)", tag, observed, expected, sel);
      end
   endtask

   // Drive a load request and push the reference frame for the selected
   // configuration, one entry per clock cycle
   task automatic applyStimulus(input logic [7:0] data);
      logic px;
      logic bits[$];
      txByte = data;
      dv     = 1'b1;
      bits.push_back(1'b0);
      px = 1'b0;
      for (int i = 0; i < dbitsOf[sel]; i++) begin
         bits.push_back(data[i]);
         px = px ^ data[i];
      end
      if (parOf[sel] == PARITY_EVEN) bits.push_back(px);
      if (parOf[sel] == PARITY_ODD)  bits.push_back(~px);
      for (int i = 0; i < stopOf[sel]; i++) bits.push_back(1'b1);
      foreach (bits[b]) begin
         for (int c = 0; c < CPB; c++) expQ.push_back(bits[b]);
      end
   endtask

   // Wait for the accept edge, then compare every frame cycle and the Done
   // cycle. With holdDv the request stays high (and the bus is scrambled)
   // so the next frame is loaded at the first IDLE edge after Done.
   task automatic checkOutput(input string tag, input bit holdDv, input logic [7:0] nextByte);
      int   f;
      logic e;
      f = expQ.size();
      @(posedge clk);
      for (int k = 1; k <= f; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (holdDv) txByte = ~txByte;
            else        dv = 1'b0;
         end
         e = expQ.pop_front();
         check({tag, "_line"},   lineS,   e);
         check({tag, "_active"}, activeS, 1'b1);
         check({tag, "_done"},   doneS,   1'b0);
         check({tag, "_ready"},  readyS,  1'b0);
      end
      @(negedge clk);
      check({tag, "_donePulse"},  doneS,   1'b1);
      check({tag, "_doneActive"}, activeS, 1'b0);
      check({tag, "_doneReady"},  readyS,  1'b1);
      check({tag, "_doneLine"},   lineS,   1'b1);
      if (holdDv) begin
         applyStimulus(nextByte);
      end else begin
         @(negedge clk);
         check({tag, "_doneOneCycle"}, doneS, 1'b0);
      end
   endtask

   initial begin
      int   doneSeen;
      int   lowSeen;
      logic e;

      reset  = 1'b1;
      dv     = 1'b0;
      txByte = 8'h00;
      sel    = 0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         check("rst_line",   lineS,   1'b1);
         check("rst_active", activeS, 1'b0);
         check("rst_done",   doneS,   1'b0);
         check("rst_ready",  readyS,  1'b1);
      end
      @(negedge clk);
      reset = 1'b0;
      sel   = 0;
      @(negedge clk);

      $display("[TB] 8N1 frame 0x55");
      applyStimulus(8'h55);
      checkOutput("8N1_55", 1'b0, 8'h00);

      $display("[TB] 8E1 and 8O1 frames 0x03");
      sel = 1;
      applyStimulus(8'h03);
      checkOutput("8E1_03", 1'b0, 8'h00);
      sel = 2;
      applyStimulus(8'h03);
      checkOutput("8O1_03", 1'b0, 8'h00);

      $display("[TB] 7E2 frame 0x41");
      sel = 3;
      applyStimulus(8'h41);
      checkOutput("7E2_41", 1'b0, 8'h00);

      $display("[TB] back-to-back frames with DV held");
      sel = 0;
      applyStimulus(8'hA5);
      checkOutput("b2b_A5", 1'b1, 8'h5A);
      checkOutput("b2b_5A", 1'b1, 8'hFF);
      checkOutput("b2b_FF", 1'b0, 8'h00);

      $display("[TB] reset in the middle of a frame");
      applyStimulus(8'h3C);
      @(posedge clk);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k == 1) dv = 1'b0;
         e = expQ.pop_front();
         check("midRst_line", lineS, e);
         if (k == 17) reset = 1'b1;
      end
      @(negedge clk);
      check("midRst_line1",  lineS,   1'b1);
      check("midRst_active", activeS, 1'b0);
      check("midRst_ready",  readyS,  1'b1);
      check("midRst_done",   doneS,   1'b0);
      reset = 1'b0;
      expQ.delete();
      doneSeen = 0;
      lowSeen  = 0;
      repeat (60) begin
         @(negedge clk);
         if (doneS) doneSeen++;
         if (!lineS) lowSeen++;
      end
      check("midRst_noDone",   doneSeen != 0, 1'b0);
      check("midRst_lineIdle", lowSeen != 0,  1'b0);

      $display("[TB] frame after reset");
      applyStimulus(8'hC3);
      checkOutput("postRst_C3", 1'b0, 8'h00);

      $display("[TB] reset and DV in the same idle cycle");
      reset  = 1'b1;
      dv     = 1'b1;
      txByte = 8'h00;
      @(negedge clk);
      check("rstDv_line",   lineS,   1'b1);
      check("rstDv_active", activeS, 1'b0);
      check("rstDv_ready",  readyS,  1'b1);
      reset = 1'b0;
      dv    = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rstDv_lineAfter",   lineS,   1'b1);
         check("rstDv_activeAfter", activeS, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter and the successor to the fixed 8N1 transmitter. It supports a configurable data width, parity mode (none/odd/even) and stop-bit count, and uses a ready/valid load handshake. Synchronous active-high reset returns the line to idle mid-frame. It sits between the command/response controller and the RS-232 pin, and drives `o_Tx_Serial` directly to the pad.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range ≥2.
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..9.
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame. Legal values 1 or 2.
- `i_Clock`, in, 1: single clock. All logic on the rising edge.
- `i_Reset`, in, 1: synchronous, active-high reset.
- `i_Tx_DV`, in, 1: load request (valid).
- `i_Tx_Byte`, in, DATA_BITS: frame data, transmitted LSB first.
- `o_Tx_Ready`, out, 1: high when a load will be accepted (state IDLE).
- `o_Tx_Active`, out, 1: high while a frame is on the line.
- `o_Tx_Serial`, out, 1: serial line, registered. Idles high.
- `o_Tx_Done`, out, 1: one-cycle pulse at frame completion.

## Operation
- States: IDLE → START → DATA → [PARITY, only if PARITY≠0] → STOP → IDLE. Unused encodings go to IDLE with the line high.
- Accept condition: `i_Tx_DV && o_Tx_Ready`. On accept:
  - latch `i_Tx_Byte` and compute the parity bit;
  - drive `o_Tx_Serial` 0 and set `o_Tx_Active` 1;
  - clear the bit counter and bit index, then enter START.
- `i_Tx_DV` outside IDLE is ignored. There is no queuing; the request is dropped.
- Bit counter: width `$clog2(CLKS_PER_BIT)`, minimum 1. It counts 0..CLKS_PER_BIT-1. At terminal count it resets to 0 and the line moves to the next bit.
- DATA: drives `data[idx]`, with idx running 0..DATA_BITS-1 (4-bit index).
- Parity bit value:
  - even: XOR of all DATA_BITS data bits;
  - odd: inverted XOR of all DATA_BITS data bits.
  - It is computed from the latched data, never from live `i_Tx_Byte`.
- STOP: drives 1 for STOP_BITS×CLKS_PER_BIT cycles. At its terminal count:
  - `o_Tx_Done` is 1 for exactly one cycle;
  - `o_Tx_Active` goes to 0;
  - state goes to IDLE, so `o_Tx_Ready` is 1.
- Back-to-back: a DV held high is accepted in the first IDLE cycle after Done. The line never stays high for less than the stop-bit time between frames.
- Reset values, applied at the next edge whenever `i_Reset`=1 (including mid-frame):
  - `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, state IDLE (`o_Tx_Ready`=1), counters 0.
  - A frame in progress is abandoned with no Done pulse.
  - Reset has priority over DV in the same cycle.

## Timing
- Accept at edge t: the start bit occupies cycles t+1..t+CLKS_PER_BIT.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS).
- The line is driven for cycles t+1..t+F.
- `o_Tx_Done` pulses in cycle t+F+1. In that cycle `o_Tx_Ready`=1 and `o_Tx_Active`=0.
- `o_Tx_Ready` is decoded from the state register. There is no combinational path from `i_Tx_DV`.
- Earliest next accept: edge t+F+1, so frame-to-frame spacing is F+1 cycles.

## Structure
- Package `uart_pkg` holds:
  - the state encoding (`S_IDLE`, `S_START`, `S_DATA`, `S_PARITY`, `S_STOP`);
  - the parity constants `PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN`;
  - the default clocks-per-bit constant, shared with the future `uart_rx_cfg`.
- Sub-module `uart_bit_timer`:
  - parametrised by CLKS_PER_BIT;
  - inputs: clear and enable; output: a `tick` at terminal count;
  - reused by the receiver.
- Elaboration-time checks on the legal parameter ranges.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- 8N1, accept 0x55 → line 0,1,0,1,0,1,0,1,0,1, 4 cycles each. Done pulses at t+41 for one cycle; Active high for cycles t+1..t+40.
- 8E1, 0x03 → parity bit 0. 8O1, 0x03 → parity bit 1. F=44, Done at t+45.
- DATA_BITS=7, even parity, 2 stop bits, 0x41 → data 1,0,0,0,0,0,1, parity 0, line high for 8 cycles. F=44.
- DV held high for 3 frames 0xA5, 0x5A, 0xFF → each frame starts exactly 1 cycle after the previous Done. DV pulses mid-frame are ignored; the data is unchanged.
- Reset asserted at cycle t+17 of an 8N1 frame → at t+18 line=1, Active=0, Ready=1, no Done pulse. The next accepted frame is bit-exact.
- Reset and DV in the same IDLE cycle → not accepted; the line stays 1.
